// File: rtl/cache_color_pkg.sv
// Shared widths, word/colour types and the colour packing helper for cache_color.
package cache_color_pkg;

    localparam int WORD_W     = 16;
    localparam int COLOR_W    = 24;
    localparam int NUM_COLORS = 3;
    localparam int ADDR_W     = 3;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [COLOR_W-1:0] color_t;

    // Only the low byte of the high word is visible; its upper byte is stored but hidden.
    function automatic color_t pack_color(input word_t hi_word, input word_t lo_word);
        return {hi_word[COLOR_W-WORD_W-1:0], lo_word};
    endfunction

endpackage

// File: rtl/cache_color_bank.sv
// One colour entry: a low/high word pair with write and shift-in ports.
// With CACHE_COLOR_VALID_EN defined, the entry also tracks a valid bit.
module cache_color_bank
    import cache_color_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   shift,
    input  logic   we_lo,
    input  logic   we_hi,
    input  word_t  di,
    input  word_t  shift_lo_in,
    input  word_t  shift_hi_in,
`ifdef CACHE_COLOR_VALID_EN
    input  logic   shift_valid_in,
    output logic   valid,
`endif
    output word_t  lo_word,
    output word_t  hi_word,
    output color_t color
);

    // A shift takes precedence over any addressed write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_word <= '0;
            hi_word <= '0;
        end else if (shift) begin
            lo_word <= shift_lo_in;
            hi_word <= shift_hi_in;
        end else begin
            if (we_lo) lo_word <= di;
            if (we_hi) hi_word <= di;
        end
    end

`ifdef CACHE_COLOR_VALID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= 1'b0;
        else if (shift)
            valid <= shift_valid_in;
        else if (we_lo || we_hi)
            valid <= 1'b1;
    end
`endif

    assign color = pack_color(hi_word, lo_word);

endmodule

// File: rtl/cache_color.sv
// Six-word register cache presented as three parallel 24-bit colour entries.
// Optional CACHE_COLOR_VALID_EN adds a per-entry valid output.
module cache_color
    import cache_color_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              SH,
    input  logic              WE,
    input  word_t             di,
    input  logic [ADDR_W-1:0] address,
`ifdef CACHE_COLOR_VALID_EN
    output logic [NUM_COLORS-1:0] valid,
`endif
    output color_t            cache_out [0:NUM_COLORS-1]
);

    word_t lo_words [NUM_COLORS];
    word_t hi_words [NUM_COLORS];
    word_t shift_lo [NUM_COLORS];
    word_t shift_hi [NUM_COLORS];
`ifdef CACHE_COLOR_VALID_EN
    logic [NUM_COLORS-1:0] shift_valid;
`endif

    for (genvar i = 0; i < NUM_COLORS; i++) begin : g_bank
        // Each bank shifts from the one above; the top bank takes di with a cleared high word.
        if (i == NUM_COLORS - 1) begin : g_top
            assign shift_lo[i] = di;
            assign shift_hi[i] = '0;
`ifdef CACHE_COLOR_VALID_EN
            assign shift_valid[i] = 1'b1;
`endif
        end else begin : g_chain
            assign shift_lo[i] = lo_words[i+1];
            assign shift_hi[i] = hi_words[i+1];
`ifdef CACHE_COLOR_VALID_EN
            assign shift_valid[i] = valid[i+1];
`endif
        end

        // Addresses 6 and 7 match no bank, so such writes drop silently.
        cache_color_bank u_bank (
            .clk         (clk),
            .rst         (rst),
            .shift       (SH),
            .we_lo       (WE && (address == ADDR_W'(2*i))),
            .we_hi       (WE && (address == ADDR_W'(2*i + 1))),
            .di          (di),
            .shift_lo_in (shift_lo[i]),
            .shift_hi_in (shift_hi[i]),
`ifdef CACHE_COLOR_VALID_EN
            .shift_valid_in (shift_valid[i]),
            .valid          (valid[i]),
`endif
            .lo_word     (lo_words[i]),
            .hi_word     (hi_words[i]),
            .color       (cache_out[i])
        );
    end

endmodule

// File: tb/tb_cache_color.sv
// Directed table-driven bench for cache_color with hand-computed colour entries.
module tb_cache_color;
    import cache_color_pkg::*;

    logic        clk;
    logic        rst;
    logic        SH;
    logic        WE;
    word_t       di;
    logic [2:0]  address;
    color_t      cache_out [0:2];
`ifdef CACHE_COLOR_VALID_EN
    logic [2:0]  valid;
`endif

    int errors = 0;
    int checks = 0;

    cache_color dut (
        .clk       (clk),
        .rst       (rst),
        .SH        (SH),
        .WE        (WE),
        .di        (di),
        .address   (address),
`ifdef CACHE_COLOR_VALID_EN
        .valid     (valid),
`endif
        .cache_out (cache_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       sh;
        logic       we;
        logic [15:0] d;
        logic [2:0] addr;
        logic [23:0] e0;
        logic [23:0] e1;
        logic [23:0] e2;
    } vec_t;

    vec_t vecs [$];

    task automatic checkOutput(input string name, input logic [23:0] e0,
                               input logic [23:0] e1, input logic [23:0] e2);
        logic [23:0] exp_v [3];
        exp_v[0] = e0;
        exp_v[1] = e1;
        exp_v[2] = e2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cache_out[i] !== exp_v[i]) begin
                errors++;
                $display("[TB] FAIL %s cache_out[%0d]: got %h expected %h", name, i, cache_out[i], exp_v[i]);
            end
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic sh, input logic we, input logic [15:0] d,
                                 input logic [2:0] addr);
        @(negedge clk);
        SH      = sh;
        WE      = we;
        di      = d;
        address = addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; SH = 1'b0; WE = 1'b0; di = '0; address = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 24'h000000, 24'h000000, 24'h000000);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{"wr0",   0, 1, 16'hFAFD, 3'd0, 24'h00FAFD, 24'h000000, 24'h000000});
        vecs.push_back('{"wr1",   0, 1, 16'hAABB, 3'd1, 24'hBBFAFD, 24'h000000, 24'h000000});
        vecs.push_back('{"wr2",   0, 1, 16'h9918, 3'd2, 24'hBBFAFD, 24'h009918, 24'h000000});
        vecs.push_back('{"wr3",   0, 1, 16'h7744, 3'd3, 24'hBBFAFD, 24'h449918, 24'h000000});
        vecs.push_back('{"wr4",   0, 1, 16'h33CC, 3'd4, 24'hBBFAFD, 24'h449918, 24'h0033CC});
        vecs.push_back('{"wr5",   0, 1, 16'h1155, 3'd5, 24'hBBFAFD, 24'h449918, 24'h5533CC});
        vecs.push_back('{"shift1",1, 0, 16'h7744, 3'd3, 24'h449918, 24'h5533CC, 24'h007744});
        vecs.push_back('{"idle1", 0, 0, 16'h5454, 3'd0, 24'h449918, 24'h5533CC, 24'h007744});
        vecs.push_back('{"idle2", 0, 0, 16'h5454, 3'd0, 24'h449918, 24'h5533CC, 24'h007744});
        vecs.push_back('{"shift2",1, 0, 16'h7474, 3'd0, 24'h5533CC, 24'h007744, 24'h007474});
        vecs.push_back('{"sh_we", 1, 1, 16'h1234, 3'd0, 24'h007744, 24'h007474, 24'h001234});
        vecs.push_back('{"wr_a6", 0, 1, 16'hFFFF, 3'd6, 24'h007744, 24'h007474, 24'h001234});
        vecs.push_back('{"wr_a7", 0, 1, 16'hEEEE, 3'd7, 24'h007744, 24'h007474, 24'h001234});
        vecs.push_back('{"wr3b",  0, 1, 16'hABCD, 3'd3, 24'h007744, 24'hCD7474, 24'h001234});
        vecs.push_back('{"wr5b",  0, 1, 16'hBEEF, 3'd5, 24'h007744, 24'hCD7474, 24'hEF1234});
        vecs.push_back('{"shift3",1, 0, 16'h0001, 3'd2, 24'hCD7474, 24'hEF1234, 24'h000001});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sh, vecs[i].we, vecs[i].d, vecs[i].addr);
            checkOutput(vecs[i].name, vecs[i].e0, vecs[i].e1, vecs[i].e2);
        end

        // Asynchronous clear between edges must show before the next rising edge.
        applyStimulus(0, 0, 16'h0000, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 24'h000000, 24'h000000, 24'h000000);

        // A write pending while reset is held must not land.
        @(negedge clk);
        WE = 1'b1; di = 16'h1111; address = 3'd0;
        @(posedge clk);
        #1;
        checkOutput("rst_hold", 24'h000000, 24'h000000, 24'h000000);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_wr", 24'h001111, 24'h000000, 24'h000000);

        applyStimulus(1, 0, 16'h2222, 3'd0);
        checkOutput("post_rst_sh", 24'h000000, 24'h000000, 24'h002222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
